// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a first-word-fall-through FIFO into a valid/ready stream through a registered skid buffer
// Ports: clk/rst (sync, active-high); fifo_empty/fifo_data/fifo_pop face the FIFO;
// m_valid/m_ready/m_data form the output stream; occupancy = words buffered; pop_count = pops since reset.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_empty,
  input  logic [WIDTH-1:0]              fifo_data,
  output logic                          fifo_pop,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WIDTH-1:0]              m_data,
  output logic [$clog2(SKID_DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]              pop_count
);
  localparam int AW = $clog2(SKID_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(SKID_DEPTH);
  logic [AW:0] cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] entry [SKID_DEPTH];
  logic xfer;
  // pop depends only on buffer fill, never on m_ready, so there is no ready-to-pop path
  assign fifo_pop = !rst && !fifo_empty && (cnt < FULL);
  assign m_valid = cnt != '0;
  assign m_data = entry[rd_ptr];
  assign occupancy = cnt;
  assign xfer = m_valid && m_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pop_count <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) entry[i] <= '0;
    end else begin
      if (fifo_pop) begin
        entry[wr_ptr] <= fifo_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      if (fifo_pop && !xfer) cnt <= cnt + 1'b1;
      else if (xfer && !fifo_pop) cnt <= cnt - 1'b1;
      pop_count <= pop_count + CNT_W'(fifo_pop);
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized and directed scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int W = 8;
  localparam int D = 2;
  localparam int CW = 4;
  logic clk = 0;
  logic rst = 1;
  logic fifo_empty;
  logic [W-1:0] fifo_data;
  logic fifo_pop;
  logic m_valid;
  logic m_ready = 0;
  logic [W-1:0] m_data;
  logic [$clog2(D):0] occupancy;
  logic [CW-1:0] pop_count;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q [$];
  int exp_pc = 0;
  logic stalled = 0;
  logic [W-1:0] last_d = '0;

  fifo_stream_reader #(.WIDTH(W), .SKID_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occupancy(occupancy), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = fifo_q.size() == 0;
    fifo_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_q.push_back(d);
    refresh();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    refresh();
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("pop_in_reset", fifo_pop, 0);
        exp_q.delete();
        exp_pc = 0;
        stalled = 0;
      end else begin
        chk("occupancy", occupancy, exp_q.size());
        chk("m_valid", m_valid, exp_q.size() != 0);
        chk("pop_count", pop_count, exp_pc % (1 << CW));
        chk("fifo_pop", fifo_pop, !fifo_empty && exp_q.size() < D);
        if (stalled) chk("stable", m_data, last_d);
        stalled = m_valid && !m_ready;
        last_d = m_data;
        if (m_valid && m_ready && exp_q.size() != 0) chk("m_data", m_data, exp_q.pop_front());
        if (fifo_pop) begin
          exp_q.push_back(fifo_data);
          exp_pc++;
          @(posedge clk);
          #1;
          void'(fifo_q.pop_front());
          refresh();
        end
      end
    end
  end

  initial begin
    cyc(2);
    rst = 0;
    m_ready = 1;
    cyc(10);
    push(8'h11); push(8'h22); push(8'h33);
    cyc(6);
    #3;
    chk("stream_pop_count", pop_count, 3);
    chk("stream_occupancy", occupancy, 0);
    cyc(1);
    m_ready = 0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    cyc(4);
    #3;
    chk("bp_occupancy", occupancy, 2);
    chk("bp_fifo_pop", fifo_pop, 0);
    chk("bp_m_data", m_data, 8'hA0);
    cyc(1);
    m_ready = 1;
    cyc(10);
    for (int i = 0; i < 8; i++) push(i[0] ? 8'hAA : 8'h55);
    cyc(12);
    m_ready = 0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    cyc(3);
    #3;
    chk("pre_reset_occupancy", occupancy, 2);
    cyc(1);
    rst = 1;
    cyc(1);
    rst = 0;
    #3;
    chk("post_reset_m_valid", m_valid, 0);
    chk("post_reset_pop_count", pop_count, 0);
    chk("post_reset_pop_resume", fifo_pop, 1);
    m_ready = 1;
    cyc(10);
    rst = 1;
    cyc(1);
    rst = 0;
    for (int i = 0; i < 17; i++) push(8'(i * 7));
    cyc(25);
    #3;
    chk("wrap_pop_count", pop_count, 17 % (1 << CW));
    repeat (3000) begin
      cyc(1);
      m_ready = $urandom_range(0, 3) != 0;
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push(8'($urandom));
      rst = $urandom_range(0, 199) == 0;
    end
    rst = 0;
    m_ready = 1;
    cyc(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
